// File: rtl/seq_frame_tx.sv
// rtl/seq_frame_tx.sv - serial frame transmitter: SYNC pattern, MSB-first payload, zero gap
module seq_frame_tx #(
   parameter int                DATA_W  = 8,
   parameter int                SYNC_W  = 4,
   parameter logic [SYNC_W-1:0] SYNC    = 4'b1011,
   parameter int                GAP_LEN = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid,
   input  logic [DATA_W-1:0] data_in,
   output logic              ready,
   output logic              out,
   output logic              out_en,
   output logic              busy,
   output logic              done
);

   localparam int MAX_LEN = (SYNC_W > DATA_W) ? ((SYNC_W > GAP_LEN) ? SYNC_W : GAP_LEN)
                                               : ((DATA_W > GAP_LEN) ? DATA_W : GAP_LEN);
   localparam int CNT_W = $clog2(MAX_LEN + 1);
   localparam int SH_W  = SYNC_W + DATA_W;

   localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SYNC = 2'd1,
      S_DATA = 2'd2,
      S_GAP  = 2'd3
   } state_t;

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [SH_W-1:0]   sh, sh_nx;
   logic [SH_W-1:0]   load_word;
   logic              out_nx, out_en_nx, busy_nx, done_nx;

   // Sync and payload share one shift register so both phases just emit the MSB.
   assign load_word = {SYNC, data_in};
   assign ready     = (state == S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt    <= '0;
         sh     <= '0;
         out    <= 1'b0;
         out_en <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         sh     <= sh_nx;
         out    <= out_nx;
         out_en <= out_en_nx;
         busy   <= busy_nx;
         done   <= done_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      sh_nx     = sh;
      out_nx    = 1'b0;
      out_en_nx = 1'b0;
      busy_nx   = 1'b0;
      done_nx   = 1'b0;

      case (state)
         S_IDLE: begin
            if (valid) begin
               state_nx  = S_SYNC;
               cnt_nx    = SYNC_LAST;
               out_nx    = load_word[SH_W-1];
               sh_nx     = load_word << 1;
               out_en_nx = 1'b1;
               busy_nx   = 1'b1;
            end
         end

         S_SYNC, S_DATA: begin
            out_nx    = sh[SH_W-1];
            sh_nx     = sh << 1;
            out_en_nx = 1'b1;
            busy_nx   = 1'b1;
            if (cnt != '0) begin
               cnt_nx = cnt - CNT_ONE;
            end else if (state == S_SYNC) begin
               state_nx = S_DATA;
               cnt_nx   = DATA_LAST;
            end else begin
               state_nx  = S_GAP;
               cnt_nx    = GAP_LAST;
               sh_nx     = sh;
               out_nx    = 1'b0;
               out_en_nx = 1'b0;
               done_nx   = 1'b1;
            end
         end

         S_GAP: begin
            if (cnt != '0) begin
               cnt_nx  = cnt - CNT_ONE;
               busy_nx = 1'b1;
            end else begin
               state_nx = S_IDLE;
               cnt_nx   = '0;
            end
         end

         default: begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_frame_tx.sv
// tb/tb_seq_frame_tx.sv - directed bench for seq_frame_tx with a 1011 detector loopback
module tb_seq_frame_tx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       valid0, valid1;
   logic [7:0] data0;
   logic [0:0] data1;
   logic       ready0, out0, out_en0, busy0, done0;
   logic       ready1, out1, out_en1, busy1, done1;
   logic [2:0] det;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   seq_frame_tx u_dut0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (valid0),
      .data_in (data0),
      .ready   (ready0),
      .out     (out0),
      .out_en  (out_en0),
      .busy    (busy0),
      .done    (done0)
   );

   seq_frame_tx #(.DATA_W(1), .GAP_LEN(3)) u_dut1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid   (valid1),
      .data_in (data1),
      .ready   (ready1),
      .out     (out1),
      .out_en  (out_en1),
      .busy    (busy1),
      .done    (done1)
   );

   // Overlapping 1011 Moore detector; state 4 means the pattern was just seen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) det <= 3'd0;
      else begin
         case (det)
            3'd0:    det <= out0 ? 3'd1 : 3'd0;
            3'd1:    det <= out0 ? 3'd1 : 3'd2;
            3'd2:    det <= out0 ? 3'd3 : 3'd0;
            3'd3:    det <= out0 ? 3'd4 : 3'd2;
            3'd4:    det <= out0 ? 3'd1 : 3'd2;
            default: det <= 3'd0;
         endcase
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic accept0(input logic [7:0] word);
      @(negedge clk);
      valid0 = 1'b1;
      data0  = word;
      @(posedge clk);
      #1 valid0 = 1'b0;
   endtask

   task automatic frame_a5(input string pfx);
      logic [13:0] f;
      f = {4'b1011, 8'hA5, 2'b00};
      accept0(8'hA5);
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         check($sformatf("%s_out[%0d]", pfx, k), out0, f[14-k]);
         check($sformatf("%s_en[%0d]", pfx, k), out_en0, k <= 12);
         check($sformatf("%s_busy[%0d]", pfx, k), busy0, k <= 14);
         check($sformatf("%s_done[%0d]", pfx, k), done0, k == 13);
         check($sformatf("%s_rdy[%0d]", pfx, k), ready0, 1'b0);
      end
      @(negedge clk);
      check({pfx, "_rdy15"}, ready0, 1'b1);
      check({pfx, "_busy15"}, busy0, 1'b0);
   endtask

   initial begin
      logic [29:0] f3;
      logic [9:0]  f6;
      int          hits, hit_cyc;

      rst_n  = 1'b0;
      valid0 = 1'b1;
      data0  = 8'hA5;
      valid1 = 1'b0;
      data1  = 1'b0;

      // reset with valid held high
      repeat (3) @(negedge clk);
      check("t1_out", out0, 1'b0);
      check("t1_ready", ready0, 1'b1);
      check("t1_busy", busy0, 1'b0);
      check("t1_out_en", out_en0, 1'b0);
      check("t1_done", done0, 1'b0);
      check("t1_ready1", ready1, 1'b1);
      rst_n  = 1'b1;
      valid0 = 1'b0;

      frame_a5("t2");

      // back-to-back with valid held; data change while busy is ignored
      f3 = {4'b1011, 8'h3C, 2'b00, 1'b0, 4'b1011, 8'hFF, 2'b00, 1'b0};
      @(negedge clk);
      valid0 = 1'b1;
      data0  = 8'h3C;
      @(posedge clk);
      #1 data0 = 8'hFF;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         check($sformatf("t3_out[%0d]", k), out0, f3[30-k]);
         if (k == 15) check("t3_rdy15", ready0, 1'b1);
         if (k == 16) check("t3_rdy16", ready0, 1'b0);
         if (k == 29) valid0 = 1'b0;
      end

      // loopback into detector with a zero payload
      hits    = 0;
      hit_cyc = 0;
      accept0(8'h00);
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (det == 3'd4) begin
            hits++;
            hit_cyc = k;
         end
         if (k == 15) check("t4_det_idle", det, 3'd0);
      end
      check("t4_hits", hits, 1);
      check("t4_hit_cyc", hit_cyc, 5);

      // asynchronous reset mid-frame, then a clean frame
      accept0(8'hA5);
      repeat (7) @(negedge clk);
      check("t5_out_c7", out0, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_out_rst", out0, 1'b0);
      check("t5_busy_rst", busy0, 1'b0);
      check("t5_en_rst", out_en0, 1'b0);
      check("t5_rdy_rst", ready0, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      frame_a5("t5");

      // narrow instance: one data bit, three gap cycles
      f6 = 10'b1011100001;
      @(negedge clk);
      valid1 = 1'b1;
      data1  = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         check($sformatf("t6_out[%0d]", k), out1, f6[10-k]);
         check($sformatf("t6_done[%0d]", k), done1, k == 6);
         if (k == 9) check("t6_rdy9", ready1, 1'b1);
         if (k == 10) valid1 = 1'b0;
      end
      for (int i = 0; i < 20 && !ready1; i++) @(negedge clk);
      check("t6_drain", ready1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
